// File: rtl/i2c_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_bridge_ctrl
//
// Sits between the I2C slave receiver and the UART transmitter of the
// I2C-to-UART bridge. Write payload addressed to this device is buffered
// in a payload FIFO and drained to the UART over a valid/ready handshake.
// The block decides ACK/NACK for every address and data byte, and raises a
// sticky overflow flag whenever a byte has to be dropped.
//
// Build option:
//   BRIDGE_FRAME_EN - when defined, every accepted write is wrapped as
//                     SOF_BYTE, payload..., trailer. The trailer is the
//                     payload count mod 256. One FIFO slot is always kept
//                     free for the trailer. When undefined, the UART
//                     stream is the payload only.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   i2c_start        START / repeated START pulse
//   i2c_stop         STOP pulse
//   i2c_addr_valid   address phase complete; qualified by i2c_addr_match
//                    and i2c_rw
//   i2c_byte_valid   data byte pulse; the byte is on i2c_byte
//   i2c_ack          combinational ACK (1) / NACK (0) for the current
//                    address or byte
//   tx_data          head of the FIFO (registered); stable while stalled
//   tx_valid         FIFO is not empty
//   tx_ready         UART accepts tx_data this cycle
//   fifo_level       FIFO occupancy
//   busy             state is not IDLE, or the FIFO is not empty
//   overflow         sticky dropped-byte flag
//   clr_overflow     clears overflow; a set in the same cycle wins
// ---------------------------------------------------------------------------
module i2c_bridge_ctrl #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i2c_start,
  input  logic                          i2c_stop,
  input  logic                          i2c_addr_valid,
  input  logic                          i2c_addr_match,
  input  logic                          i2c_rw,
  input  logic                          i2c_byte_valid,
  input  logic [7:0]                    i2c_byte,
  output logic                          i2c_ack,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    IGNORE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level_q, level_d;
  logic          pop, push_en, push_ok, push_payload, drop;
  logic          space, entry_ok;
  logic [7:0]    push_data;

`ifdef BRIDGE_FRAME_EN
  logic       trl_pend;    // trailer is pushed in this cycle
  logic       sof_pend;    // SOF was displaced by the trailer; push it now
  logic [7:0] pay_cnt;
  logic       enter, close_frame, refuse_full;

  // The last free slot belongs to the trailer of the open frame.
  assign space = level_q < (DEPTH_L - LW'(1));
  // A trailer being written this cycle already occupies a slot, so count
  // it; the new frame needs room for its SOF plus its own trailer.
  assign entry_ok = ({1'b0, level_q} + {{LW{1'b0}}, trl_pend})
                    <= {1'b0, DEPTH_L - LW'(2)};
  assign enter       = (state_q == IDLE) && (state_d == ACTIVE);
  assign close_frame = (state_q == ACTIVE) && (i2c_stop || i2c_start);
  assign refuse_full = (state_q == IDLE) && i2c_addr_valid &&
                       i2c_addr_match && !i2c_rw && !entry_ok;
`else
  assign space    = level_q < DEPTH_L;
  assign entry_ok = space;
`endif

  // -------------------------------------------------------------------------
  // Transaction state machine
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational blocks below use blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    i2c_ack      = 1'b0;
    push_payload = 1'b0;
    drop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i2c_addr_valid) begin
          if (i2c_addr_match && !i2c_rw && entry_ok) begin
            state_d = ACTIVE;
            i2c_ack = 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      ACTIVE: begin
        // A simultaneous stop and start is one frame close: stop first,
        // and the start then finds the block already in IDLE.
        if (i2c_stop || i2c_start) begin
          state_d = IDLE;
        end else if (i2c_byte_valid) begin
          if (space) begin
            push_payload = 1'b1;
            i2c_ack      = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      IGNORE: begin
        if (i2c_stop || i2c_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO write-port source select
  // -------------------------------------------------------------------------
  always_comb begin
    push_en   = 1'b0;
    push_data = SOF_BYTE;
`ifdef BRIDGE_FRAME_EN
    // The trailer owns the write port in its cycle; an SOF that collides
    // with it is deferred by one cycle through sof_pend. The receiver never
    // delivers a data byte in the cycle right after the address phase.
    if (trl_pend) begin
      push_en   = 1'b1;
      push_data = pay_cnt;
    end else if (sof_pend || enter) begin
      push_en   = 1'b1;
    end else if (push_payload) begin
      push_en   = 1'b1;
      push_data = i2c_byte;
    end
`else
    if (push_payload) begin
      push_en   = 1'b1;
      push_data = i2c_byte;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Payload FIFO
  // -------------------------------------------------------------------------
  assign tx_valid = (level_q != '0);
  assign pop      = tx_valid && tx_ready;
  assign push_ok  = push_en && ((level_q != DEPTH_L) || pop);
  assign rd_next  = rd_ptr + AW'(pop);
  assign level_d  = level_q + LW'(push_ok) - LW'(pop);

  // NOTE: the storage array has no reset; emptiness is tracked by the reset
  // pointers and level, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      tx_data <= 8'h00;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push_ok);
      rd_ptr  <= rd_next;
      level_q <= level_d;
      // tx_data holds the entry that will be the head after this edge. If
      // that entry is the one being written now, forward the write data.
      if (level_d != '0) begin
        if (push_ok && (wr_ptr == rd_next)) tx_data <= push_data;
        else                                tx_data <= mem[rd_next];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
`ifdef BRIDGE_FRAME_EN
    end else if (drop || refuse_full) begin
`else
    end else if (drop) begin
`endif
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef BRIDGE_FRAME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trl_pend <= 1'b0;
      sof_pend <= 1'b0;
      pay_cnt  <= 8'h00;
    end else begin
      trl_pend <= close_frame;
      sof_pend <= enter && trl_pend;
      if (enter)             pay_cnt <= 8'h00;
      else if (push_payload) pay_cnt <= pay_cnt + 8'h01;
    end
  end
`endif

  assign fifo_level = level_q;
  assign busy       = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_i2c_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_bridge_ctrl
//
// Drives the controller (FIFO_DEPTH = 4) with directed and $urandom
// I2C event sequences while the UART side applies a selectable tx_ready
// pattern. A transaction-level reference model (byte queue plus a
// write/ignore flag) predicts ACK/NACK, FIFO contents, occupancy, busy,
// overflow and the UART byte stream. Honours BRIDGE_FRAME_EN.
// ---------------------------------------------------------------------------
module tb_i2c_bridge_ctrl;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SOF   = 8'hA5;
`ifdef BRIDGE_FRAME_EN
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif

  logic       clk, rst_n;
  logic       i2c_start, i2c_stop, i2c_addr_valid, i2c_addr_match, i2c_rw;
  logic       i2c_byte_valid;
  logic [7:0] i2c_byte;
  logic       i2c_ack;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       busy, overflow, clr_overflow;

  i2c_bridge_ctrl #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(SOF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i2c_start      (i2c_start),
    .i2c_stop       (i2c_stop),
    .i2c_addr_valid (i2c_addr_valid),
    .i2c_addr_match (i2c_addr_match),
    .i2c_rw         (i2c_rw),
    .i2c_byte_valid (i2c_byte_valid),
    .i2c_byte       (i2c_byte),
    .i2c_ack        (i2c_ack),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level),
    .busy           (busy),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the UART still has to receive, whether a write
  // frame is open (1) or the current transfer is being ignored (2), and
  // the framing bookkeeping.
  logic [7:0] q[$];
  int         m_mode;
  bit         m_ovf;
  bit         m_trl;
  bit         m_sof;
  int         m_cnt;
  logic [7:0] seen[$];       // bytes the UART actually accepted
  int         rdy_mode;      // 0 low, 1 high, 2 random, 3 toggle
  bit         tog;

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_ovf  = 1'b0;
    m_trl  = 1'b0;
    m_sof  = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare outputs, then
  // advance the model to what the rising edge must produce.
  task automatic step(input logic st, input logic sp, input logic av,
                      input logic am, input logic rw, input logic bv,
                      input logic [7:0] b, input logic clr);
    int         sz;
    logic       rdy, ok, room, exp_ack;
    bit         trl_next, sof_next;
    logic [7:0] pushes[$];
    @(negedge clk);
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: begin tog = ~tog; rdy = tog; end
    endcase
    i2c_start = st; i2c_stop = sp; i2c_addr_valid = av; i2c_addr_match = am;
    i2c_rw = rw; i2c_byte_valid = bv; i2c_byte = b; tx_ready = rdy;
    clr_overflow = clr;
    #1;
    sz   = q.size();
    ok   = am && !rw && (FRAME ? (sz + int'(m_trl) <= DEPTH - 2) : (sz < DEPTH));
    room = FRAME ? (sz < DEPTH - 1) : (sz < DEPTH);
    exp_ack = (m_mode == 0 && av && ok) ||
              (m_mode == 1 && bv && !st && !sp && room);

    n_tests++;
    if (i2c_ack !== exp_ack) begin
      n_fail++; $display("FAIL ack: got %b expected %b (t=%0t)", i2c_ack, exp_ack, $time);
    end
    n_tests++;
    if (fifo_level !== ($clog2(DEPTH)+1)'(sz)) begin
      n_fail++; $display("FAIL level: got %0d expected %0d (t=%0t)", fifo_level, sz, $time);
    end
    n_tests++;
    if (tx_valid !== (sz != 0)) begin
      n_fail++; $display("FAIL tx_valid: got %b expected %b (t=%0t)", tx_valid, sz != 0, $time);
    end
    if (sz != 0) begin
      n_tests++;
      if (tx_data !== q[0]) begin
        n_fail++; $display("FAIL tx_data: got %h expected %h (t=%0t)", tx_data, q[0], $time);
      end
    end
    n_tests++;
    if (busy !== (m_mode != 0 || sz != 0)) begin
      n_fail++; $display("FAIL busy: got %b expected %b (t=%0t)", busy, m_mode != 0 || sz != 0, $time);
    end
    n_tests++;
    if (overflow !== m_ovf) begin
      n_fail++; $display("FAIL overflow: got %b expected %b (t=%0t)", overflow, m_ovf, $time);
    end
    if (tx_valid && tx_ready) seen.push_back(tx_data);

    // Advance the model.
    trl_next = 1'b0;
    sof_next = 1'b0;
    if (m_trl) pushes.push_back(8'(m_cnt));
    if (m_sof) pushes.push_back(SOF);
    case (m_mode)
      0: if (av) begin
        if (ok) begin
          m_mode = 1;
          m_cnt  = 0;
          if (FRAME) begin
            if (m_trl) sof_next = 1'b1;
            else       pushes.push_back(SOF);
          end
        end else begin
          m_mode = 2;
          if (FRAME && am && !rw) m_ovf = 1'b1;
        end
      end
      1: if (st || sp) begin
        m_mode   = 0;
        trl_next = FRAME;
      end else if (bv) begin
        if (room) begin
          pushes.push_back(b);
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      default: if (st || sp) m_mode = 0;
    endcase
    if (clr && !(m_mode == 1 && bv && !room && !st && !sp) && !(FRAME && av && am && !rw && !ok && sz >= 0))
      m_ovf = m_ovf & ~clr;
    if (sz != 0 && rdy) void'(q.pop_front());
    foreach (pushes[i]) q.push_back(pushes[i]);
    m_trl = trl_next;
    m_sof = sof_next;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask
  task automatic addr(input logic m, input logic r);
    step(0, 0, 1, m, r, 0, 8'h00, 0); idle(1);
  endtask
  task automatic data(input logic [7:0] b);
    step(0, 0, 0, 0, 0, 1, b, 0); idle(1);
  endtask
  task automatic stop_ev();
    step(0, 1, 0, 0, 0, 0, 8'h00, 0); idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i2c_start = 0; i2c_stop = 0; i2c_addr_valid = 0; i2c_addr_match = 0;
    i2c_rw = 0; i2c_byte_valid = 0; i2c_byte = 0; tx_ready = 0; clr_overflow = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got data=%h valid=%b busy=%b ovf=%b expected 00/0/0/0",
                         tx_data, tx_valid, busy, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    idle(2);
  endtask

  task automatic test_basic_write();
    logic [7:0] exp_q[$];
    seen.delete();
    rdy_mode = 1;
    addr(1, 0);
    data(8'h11); data(8'h22); data(8'h33);
    stop_ev();
    idle(6);
    if (FRAME) exp_q = '{SOF, 8'h11, 8'h22, 8'h33, 8'h03};
    else       exp_q = '{8'h11, 8'h22, 8'h33};
    n_tests++;
    if (seen.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", seen.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (seen[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, seen[i], exp_q[i]);
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_nack();
    seen.delete();
    rdy_mode = 1;
    addr(0, 0); data(8'h55); stop_ev();
    addr(1, 1); data(8'h66); stop_ev();
    idle(3);
    n_tests++;
    if (seen.size() != 0 || fifo_level !== '0) begin
      n_fail++; $display("FAIL nack_traffic: got %0d bytes level %0d expected 0 bytes level 0",
                         seen.size(), fifo_level);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    seen.delete();
    rdy_mode = 0;
    addr(1, 0);
    for (int i = 0; i < 6; i++) data(8'h61 + 8'(i));
    stop_ev();
    idle(1);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    rdy_mode = 1;
    idle(8);
    if (FRAME) exp_q = '{SOF, 8'h61, 8'h62, 8'h02};
    else       exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    n_tests++;
    if (seen.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected %0d", seen.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (seen[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, seen[i], exp_q[i]);
      end
    end
    step(0, 0, 0, 0, 0, 0, 8'h00, 1);
    idle(1);
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_stall_stream();
    rdy_mode = 3;
    tog      = 1'b0;
    addr(1, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 1, 8'($urandom), 0);
      if (i % 3 == 2) idle(1);
    end
    stop_ev();
    rdy_mode = 1;
    idle(8);
    step(0, 0, 0, 0, 0, 0, 8'h00, 1);
    idle(1);
  endtask

  task automatic test_random();
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      addr(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
      for (int k = $urandom_range(0, 5); k > 0; k--) data(8'($urandom));
      if ($urandom_range(0, 1) == 1) stop_ev();
      else step(1, 0, 0, 0, 0, 0, 8'h00, 0);
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 0, 0, 8'h00, 1);
    end
    stop_ev();
    rdy_mode = 1;
    idle(10);
  endtask

`ifdef BRIDGE_FRAME_EN
  task automatic test_frame();
    logic [7:0] exp_q[$];
    exp_q = '{SOF, 8'h01, 8'h02, 8'h02, SOF, 8'h03, 8'h01};
    seen.delete();
    rdy_mode = 1;
    addr(1, 0); data(8'h01); data(8'h02);
    step(1, 0, 0, 0, 0, 0, 8'h00, 0);
    addr(1, 0); data(8'h03);
    stop_ev();
    idle(10);
    n_tests++;
    if (seen.size() != exp_q.size()) begin
      n_fail++; $display("FAIL frame_count: got %0d expected %0d", seen.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (seen[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL frame_byte%0d: got %h expected %h", i, seen[i], exp_q[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    rdy_mode = 0;
    addr(1, 0);
    data(8'h71); data(8'h72); data(8'h73);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_valid !== 1'b0 || fifo_level !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset: got valid=%b level=%0d busy=%b expected 0/0/0",
                         tx_valid, fifo_level, busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen.delete();
    rdy_mode = 1;
    idle(6);
    n_tests++;
    if (seen.size() != 0) begin
      n_fail++; $display("FAIL midreset_traffic: got %0d bytes expected 0", seen.size());
    end
  endtask

  initial begin
    tog = 1'b0;
    rdy_mode = 1;
    test_reset();
    test_basic_write();
    test_nack();
    test_overflow();
    test_stall_stream();
    test_random();
`ifdef BRIDGE_FRAME_EN
    test_frame();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_bridge_ctrl.md
Name: i2c_bridge_ctrl

Overview:
Controller between the I2C slave receiver and the UART transmitter of the I2C-to-UART bridge. It consumes the receiver's event pulses (start, address result, data byte, stop), accepts write payload addressed to this device, and buffers it in an internal FIFO. It drains the FIFO to the UART TX over a valid/ready handshake. It also decides ACK/NACK per byte and flags overflow.

Parameters:
FIFO_DEPTH, 16, payload FIFO entries; power of two, minimum 4
SOF_BYTE, 8'hA5, frame-start marker; used only with the framing option

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
i2c_start  input  1  one-cycle pulse: START or repeated START seen
i2c_stop  input  1  one-cycle pulse: STOP seen
i2c_addr_valid  input  1  one-cycle pulse: address phase complete
i2c_addr_match  input  1  qualifies i2c_addr_valid: address equals the device address
i2c_rw  input  1  qualifies i2c_addr_valid: 1 = read, 0 = write
i2c_byte_valid  input  1  one-cycle pulse: data byte received
i2c_byte  input  8  data byte; valid with i2c_byte_valid
i2c_ack  output  1  combinational: 1 = ACK the current address or byte, 0 = NACK
tx_data  output  8  byte to the UART TX
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts tx_data this cycle
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  state is not IDLE, or FIFO is not empty
overflow  output  1  sticky flag: a byte was dropped
clr_overflow  input  1  clears overflow; set takes precedence over clear in the same cycle

Behaviour:
- Reset values: state = IDLE; FIFO empty; fifo_level = 0; tx_valid = 0; tx_data = 0; overflow = 0; busy = 0. Reset mid-transfer discards all FIFO contents and any pending trailer.
- State machine: IDLE, ACTIVE, IGNORE.
  - IDLE: on i2c_addr_valid, go to ACTIVE if i2c_addr_match = 1, i2c_rw = 0, and space is available; otherwise go to IGNORE.
  - ACTIVE: on i2c_byte_valid with space available, push i2c_byte. On i2c_byte_valid with no space, drop the byte and set overflow; state stays ACTIVE.
  - ACTIVE: on i2c_stop go to IDLE. On i2c_start, close the frame, go to IDLE and wait for the next address.
  - IGNORE: ignore all data bytes; return to IDLE on i2c_stop or i2c_start.
- Events are mutually exclusive per cycle except i2c_stop with i2c_start, where stop is processed first.
- Space available (no framing): fifo_level < FIFO_DEPTH.
- i2c_ack:
  - Address phase: 1 during i2c_addr_valid when the transition is to ACTIVE; else 0.
  - Data phase: 1 during i2c_byte_valid in ACTIVE with space available; else 0.
  - Otherwise 0.
- FIFO: single push and single pop per cycle.
  - Push and pop in the same cycle leave the level unchanged, including at full.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level saturates neither way.
- TX handshake:
  - tx_valid = 1 whenever the FIFO is non-empty; tx_data = head entry, registered.
  - A pop occurs only when tx_valid and tx_ready are both 1.
  - tx_data must not change while tx_valid = 1 and tx_ready = 0.
  - Latency: a byte pushed into an empty FIFO at cycle N appears with tx_valid = 1 at cycle N+1.
- A read request (i2c_rw = 1) is NACKed and generates no UART traffic.

Optional Feature:
Macro BRIDGE_FRAME_EN.
- Defined:
  - The ACTIVE entry pushes SOF_BYTE in the same cycle as the address ACK.
  - Closing the frame (stop or repeated start) pushes a trailer byte one cycle later, equal to the payload count mod 256. An 8-bit counter tracks payload count and clears on ACTIVE entry.
  - One FIFO slot is always reserved for the trailer:
    - ACTIVE entry requires fifo_level <= FIFO_DEPTH-2; otherwise go to IGNORE, NACK, and set overflow.
    - A payload push requires fifo_level < FIFO_DEPTH-1.
  - An i2c_addr_valid arriving in the trailer cycle is handled normally; the trailer push has priority for the FIFO write port, and the SOF is pushed the following cycle.
- Undefined: no SOF, trailer, or counter logic; the stream is payload only.

Test Plan:
- Write to a matching address, bytes 11,22,33, then stop, with tx_ready held 1 → address and all bytes ACKed; UART sees 11,22,33; busy = 0 afterwards.
- Address mismatch, then read with matching address → i2c_ack = 0 for both; fifo_level stays 0; no tx_valid.
- FIFO_DEPTH = 4, tx_ready = 0, 6 bytes written → first 4 ACKed, 5th and 6th NACKed; overflow = 1; releasing tx_ready yields exactly 4 bytes in order. clr_overflow then clears the flag.
- tx_ready toggling every cycle while bytes stream in → tx_data stable while stalled; no loss or duplication; level never exceeds FIFO_DEPTH.
- BRIDGE_FRAME_EN: bytes 01,02 then repeated START, then 03 then stop → UART sees A5,01,02,02,A5,03,01.
- Assert rst_n low with 3 bytes queued → tx_valid = 0 and fifo_level = 0 immediately; no bytes emitted after release.
